// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Bytes per instruction word; the PC advances by this on every accepted request.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Fetch-to-decode payload accompanying the instruction word.
  typedef struct packed {
    logic [31:0] instr_addr;
  } f_d_WI;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, occupancy count and empty/full flags.
// DEPTH must be a power of two (pointers wrap naturally).
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state: clear wins over push/pop; push on full and pop on empty are ignored.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : fetch_fifo

// File: rtl/fetch.sv
// Stage-1 instruction fetch: PC ownership, imem request/response handling,
// response buffering and redirect/drain control.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_bubbles counters.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall_in,
  output logic        f_valid,
  output f_d_WI       f_out,
  output logic [31:0] instr_dat_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          accept, rsp_evt, rsp_keep, pop;
  logic [CW-1:0] aq_count, rb_count;
  logic          aq_empty, aq_full, rb_empty, rb_full;
  logic [31:0]   aq_head;
  logic [63:0]   rb_head;
  logic          unused_flags;

  assign unused_flags = &{1'b0, aq_count, aq_empty, aq_full, rb_full};

  // Request channel, response classification and decode handshake.
  always_comb begin
    imem_req_valid = (state_q == RUN) & ~redirect_valid &
                     (({1'b0, in_flight_q} + {1'b0, rb_count}) < DEPTH_C);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding cannot belong to us (memory reset alongside).
    rsp_evt        = imem_rsp_valid & (in_flight_q != '0);
    rsp_keep       = rsp_evt & (state_q == RUN) & ~redirect_valid;
    f_valid        = ~rb_empty & ~redirect_valid;
    pop            = f_valid & ~stall_in;
    f_out          = '0;
    instr_dat_out  = '0;
    if (f_valid) begin
      f_out.instr_addr = rb_head[63:32];
      instr_dat_out    = rb_head[31:0];
    end
  end

  // Next-state for FSM, PC, outstanding and stale-response counters.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;

    if (accept && !rsp_evt) begin
      in_flight_d = in_flight_q + CW'(1);
    end else if (!accept && rsp_evt) begin
      in_flight_d = in_flight_q - CW'(1);
    end

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (accept) begin
          pc_d = pc_q + INSTR_BYTES;
        end
      end
      DRAIN: begin
        if (rsp_evt && drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (drop_cnt_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue is masked during a redirect, so everything still outstanding after
    // this cycle is stale; in DRAIN in_flight already equals drop_cnt.
    if (redirect_valid) begin
      pc_d       = {redirect_addr[31:2], 2'b00};
      drop_cnt_d = in_flight_d;
      state_d    = (in_flight_d != '0) ? DRAIN : RUN;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_ADDR;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (accept),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .head_data (aq_head),
    .count     (aq_count),
    .empty     (aq_empty),
    .full      (aq_full)
  );

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({aq_head, imem_rsp_data}),
    .pop       (pop),
    .head_data (rb_head),
    .count     (rb_count),
    .empty     (rb_empty),
    .full      (rb_full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Performance counter increments (free-running, wrap on overflow).
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (pop) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (!f_valid && !stall_in) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule : fetch

// File: tb/tb_fetch.sv
// Directed testbench for fetch: in-order imem model with configurable latency,
// decode-side sequence checker, and a second instance with a wrapping RESET_ADDR.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall_in;
  logic        f_valid;
  f_d_WI       f_out;
  logic [31:0] instr_dat_out;

  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        f_valid2;
  f_d_WI       f_out2;
  logic [31:0] dat2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  always #5 clk = ~clk;

  fetch #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .stall_in(stall_in),
    .f_valid(f_valid), .f_out(f_out), .instr_dat_out(instr_dat_out)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(1'b0), .redirect_addr(32'h0), .stall_in(1'b0),
    .f_valid(f_valid2), .f_out(f_out2), .instr_dat_out(dat2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];
  int unsigned cycle = 0;
  int unsigned lat   = 1;
  logic [31:0] exp_req  = 32'h0;
  logic [31:0] exp_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock: check the accepted request and popped instruction against the
  // expected sequence, then advance the memory model past the edge.
  task automatic cyc();
    logic        acc, was_rst;
    logic [31:0] a;
    #1;
    acc     = imem_req_valid & imem_req_ready;
    a       = imem_req_addr;
    was_rst = rst;
    if (!rst) begin
      if (acc) begin
        check("req_addr", a, exp_req);
        exp_req += 32'd4;
      end
      if (f_valid && !stall_in) begin
        check("dec_addr", f_out.instr_addr, exp_addr);
        check("dec_data", instr_dat_out, mk(exp_addr));
        exp_addr += 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (was_rst) pend.delete();
    else if (acc) pend.push_back('{a, cycle + lat - 1});
    if (pend.size() != 0 && pend[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mk(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    stall_in       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend.size() == 0 && !imem_rsp_valid && !f_valid) break;
      cyc();
    end
    check("drain_f_valid", f_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    stall_in = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (3) cyc();

    // Reset state, back-to-back streaming, wrapping RESET_ADDR on dut2
    rst = 1'b0; imem_req_ready = 1'b1; #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_f_valid", f_valid, 1'b0);
    check("rst_f_out", f_out.instr_addr, 32'h0);
    check("rst_dat", instr_dat_out, 32'h0);
    check("rst_req_valid2", req_valid2, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
    cyc();
    check("t1_first_req", imem_req_valid, 1'b1);
    check("t5_req_valid", req_valid2, 1'b1);
    check("t5_addr0", req_addr2, 32'hFFFF_FFF8);
    cyc();
    check("t1_f_valid_c2", f_valid, 1'b0);
    check("t5_addr1", req_addr2, 32'hFFFF_FFFC);
    cyc();
    check("t1_f_valid_c3", f_valid, 1'b1);
    check("t1_head_c3", f_out.instr_addr, 32'h0);
    check("t5_addr2", req_addr2, 32'h0000_0000);
    check("t5_head", f_out2.instr_addr, 32'hFFFF_FFF8);
    check("t5_head_dat", dat2, mk(32'h0));
    repeat (10) cyc();

    // Long decode stall: credit limit, then lossless release
    stall_in = 1'b1;
    repeat (10) cyc();
    check("t2_req_valid", imem_req_valid, 1'b0);
    check("t2_f_valid", f_valid, 1'b1);
    check("t2_outstanding", exp_req - exp_addr, 32'd16);
    stall_in = 1'b0;
    repeat (12) cyc();
    drain();

    // Redirect with two requests in flight: DRAIN drops both
    lat = 3; imem_req_ready = 1'b1; #1;
    check("t3_req_a", imem_req_valid, 1'b1);
    cyc();
    check("t3_req_b", imem_req_valid, 1'b1);
    cyc();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h0000_0103; #1;
    check("t3_redir_f_valid", f_valid, 1'b0);
    check("t3_redir_req", imem_req_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    exp_req = 32'h100; exp_addr = 32'h100; #1;
    check("t3_drain_req", imem_req_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (f_valid) seen = 1'b1;
    end
    check("t3_seen", seen, 1'b1);
    check("t3_head", f_out.instr_addr, 32'h100);
    drain();
    lat = 1;

    // Redirect coincident with a response while decode is stalled
    imem_req_ready = 1'b1;
    repeat (4) cyc();
    stall_in = 1'b1;
    cyc();
    check("t4_rsp_present", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0100; #1;
    check("t4_redir_f_valid", f_valid, 1'b0);
    check("t4_redir_req", imem_req_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0; exp_req = 32'h100; exp_addr = 32'h100; #1;
    check("t4_f_valid_after", f_valid, 1'b0);
    check("t4_req_valid", imem_req_valid, 1'b1);
    check("t4_pc", imem_req_addr, 32'h100);
    stall_in = 1'b0;
    repeat (8) cyc();

    // Reset mid-stream with three buffered entries
    drain();
    stall_in = 1'b1; imem_req_ready = 1'b1;
    repeat (3) cyc();
    imem_req_ready = 1'b0;
    repeat (3) cyc();
    check("t6_f_valid", f_valid, 1'b1);
    check("t6_buffered", exp_req - exp_addr, 32'd12);
    check("t6_head", f_out.instr_addr, exp_addr);
    rst = 1'b1;
    cyc();
    check("t6_f_valid_rst", f_valid, 1'b0);
    check("t6_req_valid_rst", imem_req_valid, 1'b0);
    check("t6_f_out_rst", f_out.instr_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_perf_fetched", perf_fetched, 32'h0);
    check("t6_perf_bubbles", perf_bubbles, 32'h0);
`endif
    rst = 1'b0; stall_in = 1'b0; imem_req_ready = 1'b1;
    exp_req = 32'h0; exp_addr = 32'h0;
    cyc();
    check("t6_req_valid", imem_req_valid, 1'b1);
    check("t6_pc", imem_req_addr, 32'h0);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch
